// File: rtl/alu_result_buffer.sv
// ALU result queue: DEPTH-entry first-word-fall-through buffer with per-entry
// zero/neg/carry/overflow flags, sticky misuse flags and a last-result register.
module alu_result_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_carry,
  input  logic                       in_overflow,
  output logic                       in_ready,
  input  logic                       read,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [3:0]                 out_flags,
  output logic [WIDTH-1:0]           last_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       push_err,
  output logic                       pop_err
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = WIDTH + 4;

  logic [EntryW-1:0] r_mem [DEPTH];

  logic [PtrW-1:0]   r_head, w_head_nxt;
  logic [PtrW-1:0]   r_tail, w_tail_nxt;
  logic [CntW-1:0]   r_count, w_count_nxt;
  logic [WIDTH-1:0]  r_last, w_last_nxt;
  logic              r_push_err, w_push_err_nxt;
  logic              r_pop_err, w_pop_err_nxt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_in_flags;
  logic [EntryW-1:0] w_head_entry;

  // Status comes from registered count only, so ready/valid never depend on write/read.
  assign w_full    = (r_count == CntW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;

  // A pop in the same cycle never frees room for a push when full.
  assign w_push = write & ~w_full & ~flush;
  assign w_pop  = read & ~w_empty & ~flush;

  assign w_in_flags = {in_overflow, in_carry, in_data[WIDTH-1], (in_data == '0)};

  always_comb begin
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_count_nxt    = r_count;
    w_last_nxt     = r_last;
    w_push_err_nxt = r_push_err;
    w_pop_err_nxt  = r_pop_err;
    if (flush) begin
      w_head_nxt     = '0;
      w_tail_nxt     = '0;
      w_count_nxt    = '0;
      w_push_err_nxt = 1'b0;
      w_pop_err_nxt  = 1'b0;
    end else begin
      if (w_push) begin
        w_tail_nxt = r_tail + PtrW'(1);
        w_last_nxt = in_data;
      end
      if (w_pop) begin
        w_head_nxt = r_head + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CntW'(1);
        2'b01:   w_count_nxt = r_count - CntW'(1);
        default: w_count_nxt = r_count;
      endcase
      if (write && w_full) begin
        w_push_err_nxt = 1'b1;
      end
      if (read && w_empty) begin
        w_pop_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_last     <= '0;
      r_push_err <= 1'b0;
      r_pop_err  <= 1'b0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_last     <= w_last_nxt;
      r_push_err <= w_push_err_nxt;
      r_pop_err  <= w_pop_err_nxt;
    end
  end

  // Storage is deliberately left unreset; out_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= {w_in_flags, in_data};
    end
  end

  assign w_head_entry = r_mem[r_head];
  assign out_data     = w_head_entry[WIDTH-1:0];
  assign out_flags    = w_head_entry[EntryW-1 -: 4];
  assign last_data    = r_last;
  assign count        = r_count;
  assign push_err     = r_push_err;
  assign pop_err      = r_pop_err;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a queue scoreboard of expected entries.
module tb_alu_result_buffer;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         write = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_carry = 1'b0;
  logic         in_overflow = 1'b0;
  logic         read = 1'b0;
  logic         flush = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   out_flags;
  logic [W-1:0] last_data;
  logic [2:0]   count;
  logic         push_err;
  logic         pop_err;

  int checks = 0;
  int failures = 0;

  logic [W+3:0] exp_q[$];
  logic [W-1:0] m_last = '0;
  logic         m_perr = 1'b0;
  logic         m_poerr = 1'b0;

  alu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .in_data    (in_data),
    .in_carry   (in_carry),
    .in_overflow(in_overflow),
    .in_ready   (in_ready),
    .read       (read),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_flags  (out_flags),
    .last_data  (last_data),
    .count      (count),
    .push_err   (push_err),
    .pop_err    (pop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [W+3:0] h;
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() != D));
    chk("last_data", 32'(last_data), 32'(m_last));
    chk("push_err", 32'(push_err), 32'(m_perr));
    chk("pop_err", 32'(pop_err), 32'(m_poerr));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("head_data", 32'(out_data), 32'(h[W-1:0]));
      chk("head_flags", 32'(out_flags), 32'(h[W+3:W]));
    end
  endtask

  // Drive one cycle from #1 after a rising edge; update the model; check after the edge.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic c, input logic o,
                       input logic r, input logic f);
    logic [W+3:0] e;
    logic [W+3:0] h;
    logic         push_ok;
    logic         pop_ok;
    int           sz;
    write = w; in_data = d; in_carry = c; in_overflow = o; read = r; flush = f;
    sz = exp_q.size();
    push_ok = w && (sz < D) && !f;
    pop_ok  = r && (sz > 0) && !f;
    if (pop_ok) begin
      h = exp_q[0];
      chk("pop_data", 32'(out_data), 32'(h[W-1:0]));
      chk("pop_flags", 32'(out_flags), 32'(h[W+3:W]));
    end
    e = {o, c, d[W-1], (d == '0), d};
    if (f) begin
      exp_q.delete();
      m_perr = 1'b0;
      m_poerr = 1'b0;
    end else begin
      if (w && sz == D) m_perr = 1'b1;
      if (r && sz == 0) m_poerr = 1'b1;
      if (pop_ok) void'(exp_q.pop_front());
      if (push_ok) begin
        exp_q.push_back(e);
        m_last = d;
      end
    end
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; flush = 1'b0;
    check_state();
  endtask

  initial begin
    // Power-on reset, asserted between edges.
    #2 reset = 1'b1;
    #1 check_state();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check_state();

    // Fill with the flag-pattern values, then overfill.
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overfill_err", 32'(push_err), 32'd1);

    // Drain in order, then underflow.
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_last", 32'(last_data), 32'h0005);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("underflow_err", 32'(pop_err), 32'd1);

    // Simultaneous push+pop at count 2, and at full.
    cycle(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pushpop_count", 32'(count), 32'd2);
    cycle(1'b1, 16'h0033, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Wrap-around: 1..10 streamed through.
    cycle(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int v = 2; v <= 10; v++) cycle(1'b1, W'(v), 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with a concurrent write at count 3, push_err still set.
    cycle(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hF303, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_err", 32'(push_err), 32'd1);
    cycle(1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_last", 32'(last_data), 32'hF303);
    cycle(1'b1, 16'h4242, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with 3 entries held.
    cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    exp_q.delete();
    m_last = '0;
    m_perr = 1'b0;
    m_poerr = 1'b0;
    check_state();
    @(posedge clk);
    #1 reset = 1'b0;
    check_state();
    cycle(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
